// File: rtl/mem_port_arbiter_if.sv
// Bus bundle between the fetch/load-store requesters, the arbiter and the
// unified 1024 x 32 memory. The arbiter uses the slave view; the pipeline
// and memory side (or a bench) uses the master view.
interface mem_port_arbiter_if #(
  parameter int AW = 10
);
  // Pipeline control
  logic          halted;

  // Instruction fetch port
  logic          if_req;
  logic [AW-1:0] if_addr;
  logic          if_gnt;
  logic          if_rvalid;
  logic [31:0]   if_rdata;

  // Data (load/store) port
  logic          dm_req;
  logic          dm_we;
  logic [AW-1:0] dm_addr;
  logic [31:0]   dm_wdata;
  logic          dm_gnt;
  logic          dm_rvalid;
  logic [31:0]   dm_rdata;

  // Memory array port
  logic          mem_en;
  logic          mem_we;
  logic [AW-1:0] mem_addr;
  logic [31:0]   mem_wdata;
  logic [31:0]   mem_rdata;

  modport slave (
    input  halted,
    input  if_req, if_addr,
    input  dm_req, dm_we, dm_addr, dm_wdata,
    input  mem_rdata,
    output if_gnt, if_rvalid, if_rdata,
    output dm_gnt, dm_rvalid, dm_rdata,
    output mem_en, mem_we, mem_addr, mem_wdata
  );

  modport master (
    output halted,
    output if_req, if_addr,
    output dm_req, dm_we, dm_addr, dm_wdata,
    output mem_rdata,
    input  if_gnt, if_rvalid, if_rdata,
    input  dm_gnt, dm_rvalid, dm_rdata,
    input  mem_en, mem_we, mem_addr, mem_wdata
  );
endinterface

// File: rtl/mem_port_arbiter.sv
// Arbiter for the single-port unified instruction/data memory.
// One transaction in flight at a time: IDLE picks a winner, ISSUE strobes the
// memory and grants, WAIT covers the remaining memory latency, RESP captures
// the read data, and the response pulse appears in the following IDLE cycle.
// DM has priority, but after MAX_DM_STREAK consecutive DM grants with IF
// waiting, IF is forced through.
// Optional: define ARB_PERF_CNT_EN to add the conflict_cnt_o counter port.
module mem_port_arbiter #(
  parameter int AW            = 10,
  parameter int MEM_LAT       = 1,
  parameter int MAX_DM_STREAK = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  mem_port_arbiter_if.slave        bus
`ifdef ARB_PERF_CNT_EN
  ,
  output logic [15:0]              conflict_cnt_o
`endif
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    RESP  = 2'd3
  } state_t;

  localparam logic [2:0] WAIT_INIT  = 3'(MEM_LAT - 1);
  localparam logic [3:0] MAX_STREAK = 4'(MAX_DM_STREAK);

  state_t        state_q, state_d;
  logic [3:0]    streak_q, streak_d;
  logic [2:0]    wait_q, wait_d;
  logic          win_dm_q, win_dm_d;
  logic [AW-1:0] addr_q, addr_d;
  logic          we_q, we_d;
  logic [31:0]   wdata_q, wdata_d;
  logic          if_rvalid_q, if_rvalid_d;
  logic          dm_rvalid_q, dm_rvalid_d;
  logic [31:0]   if_rdata_q, if_rdata_d;
  logic [31:0]   dm_rdata_q, dm_rdata_d;

  logic          pick_dm;
  logic          issuing;

  // Next-state, winner selection, streak tracking and response capture
  always_comb begin
    state_d     = state_q;
    streak_d    = streak_q;
    wait_d      = wait_q;
    win_dm_d    = win_dm_q;
    addr_d      = addr_q;
    we_d        = we_q;
    wdata_d     = wdata_q;
    if_rvalid_d = 1'b0;
    dm_rvalid_d = 1'b0;
    if_rdata_d  = if_rdata_q;
    dm_rdata_d  = dm_rdata_q;
    pick_dm     = bus.dm_req && !(bus.if_req && (streak_q == MAX_STREAK));

    case (state_q)
      IDLE: begin
        if (!bus.if_req) begin
          streak_d = 4'd0;
        end
        if (!bus.halted && (bus.if_req || bus.dm_req)) begin
          win_dm_d = pick_dm;
          state_d  = ISSUE;
          if (pick_dm) begin
            addr_d  = bus.dm_addr;
            we_d    = bus.dm_we;
            wdata_d = bus.dm_wdata;
            if (bus.if_req && (streak_q != MAX_STREAK)) begin
              streak_d = streak_q + 4'd1;
            end
          end else begin
            addr_d   = bus.if_addr;
            we_d     = 1'b0;
            wdata_d  = 32'h0;
            streak_d = 4'd0;
          end
        end
      end
      ISSUE: begin
        wait_d  = WAIT_INIT;
        state_d = (MEM_LAT == 1) ? RESP : WAIT;
      end
      WAIT: begin
        wait_d = wait_q - 3'd1;
        if (wait_q <= 3'd1) begin
          state_d = RESP;
        end
      end
      RESP: begin
        state_d = IDLE;
        if (win_dm_q) begin
          dm_rvalid_d = 1'b1;
          dm_rdata_d  = we_q ? 32'h0 : bus.mem_rdata;
        end else begin
          if_rvalid_d = 1'b1;
          if_rdata_d  = bus.mem_rdata;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and datapath registers, cleared asynchronously
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      streak_q    <= 4'd0;
      wait_q      <= 3'd0;
      win_dm_q    <= 1'b0;
      addr_q      <= '0;
      we_q        <= 1'b0;
      wdata_q     <= 32'h0;
      if_rvalid_q <= 1'b0;
      dm_rvalid_q <= 1'b0;
      if_rdata_q  <= 32'h0;
      dm_rdata_q  <= 32'h0;
    end else begin
      state_q     <= state_d;
      streak_q    <= streak_d;
      wait_q      <= wait_d;
      win_dm_q    <= win_dm_d;
      addr_q      <= addr_d;
      we_q        <= we_d;
      wdata_q     <= wdata_d;
      if_rvalid_q <= if_rvalid_d;
      dm_rvalid_q <= dm_rvalid_d;
      if_rdata_q  <= if_rdata_d;
      dm_rdata_q  <= dm_rdata_d;
    end
  end

  // Memory strobe and grants exist only in ISSUE; the memory bus idles at 0
  assign issuing       = (state_q == ISSUE);
  assign bus.mem_en    = issuing;
  assign bus.mem_we    = issuing & we_q;
  assign bus.mem_addr  = issuing ? addr_q : '0;
  assign bus.mem_wdata = issuing ? wdata_q : 32'h0;
  assign bus.if_gnt    = issuing & ~win_dm_q;
  assign bus.dm_gnt    = issuing & win_dm_q;
  assign bus.if_rvalid = if_rvalid_q;
  assign bus.if_rdata  = if_rdata_q;
  assign bus.dm_rvalid = dm_rvalid_q;
  assign bus.dm_rdata  = dm_rdata_q;

`ifdef ARB_PERF_CNT_EN
  logic [15:0] conflict_q, conflict_d;
  logic        conflict_hit;

  // Count contended IDLE grants and every cycle IF waits behind a busy port
  always_comb begin
    conflict_hit = ((state_q == IDLE) && !bus.halted && bus.if_req && bus.dm_req) ||
                   ((state_q != IDLE) && bus.if_req);
    conflict_d   = conflict_q;
    if (conflict_hit && (conflict_q != 16'hFFFF)) begin
      conflict_d = conflict_q + 16'd1;
    end
  end

  // Saturating conflict counter register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      conflict_q <= 16'h0;
    end else begin
      conflict_q <= conflict_d;
    end
  end

  assign conflict_cnt_o = conflict_q;
`endif

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: instance A runs MEM_LAT=1, instance B
// runs MEM_LAT=3; each has its own simple latency-accurate memory model.
module tb_mem_port_arbiter;
  localparam int AW = 10;

  logic clk = 1'b0;
  logic rst_n;
  int   errors;
  int   checks;

  always #5 clk = ~clk;

  mem_port_arbiter_if #(.AW(AW)) busA ();
  mem_port_arbiter_if #(.AW(AW)) busB ();

`ifdef ARB_PERF_CNT_EN
  logic [15:0] conflictA;
  logic [15:0] conflictB;
`endif

  mem_port_arbiter #(.AW(AW), .MEM_LAT(1), .MAX_DM_STREAK(4)) dutA (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (busA)
`ifdef ARB_PERF_CNT_EN
    ,
    .conflict_cnt_o (conflictA)
`endif
  );

  mem_port_arbiter #(.AW(AW), .MEM_LAT(3), .MAX_DM_STREAK(4)) dutB (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (busB)
`ifdef ARB_PERF_CNT_EN
    ,
    .conflict_cnt_o (conflictB)
`endif
  );

  // Memory A: data valid one cycle after mem_en; preloaded while in reset
  logic [31:0] memA [1024];
  logic [31:0] rdA;
  always @(posedge clk) begin
    if (!rst_n) begin
      memA[5] <= 32'h2842_000A;
    end else if (busA.mem_en && busA.mem_we) begin
      memA[busA.mem_addr] <= busA.mem_wdata;
    end
    rdA <= busA.mem_en ? memA[busA.mem_addr] : 32'h0;
  end
  assign busA.mem_rdata = rdA;

  // Memory B: data valid three cycles after mem_en; preloaded while in reset
  logic [31:0] memB [1024];
  logic [31:0] pipeB0, pipeB1, pipeB2;
  always @(posedge clk) begin
    if (!rst_n) begin
      memB[5] <= 32'h2842_000A;
      memB[7] <= 32'h1234_5678;
      memB[9] <= 32'hAAAA_5555;
    end else if (busB.mem_en && busB.mem_we) begin
      memB[busB.mem_addr] <= busB.mem_wdata;
    end
    pipeB0 <= busB.mem_en ? memB[busB.mem_addr] : 32'h0;
    pipeB1 <= pipeB0;
    pipeB2 <= pipeB1;
  end
  assign busB.mem_rdata = pipeB2;

  // Advance to just after the next rising edge
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Hard stop if the directed sequence ever stalls
  initial begin
    #100000;
    $display("[TB] FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin : applyStimulus
    logic expDm [10];
    int   cyc, lastCyc, waited;
    int   memEnCnt, memEnCyc, gntCnt, gntCyc, rvCnt, rvCyc;
    int   dmGntCyc, dmRvCyc, ifGntCnt, ifGntCyc, ifRvCyc;
    logic [31:0] rvData, dmRvData;

    errors = 0;
    checks = 0;
    rst_n  = 1'b0;
    busA.halted = 1'b0; busA.if_req = 1'b0; busA.if_addr = '0;
    busA.dm_req = 1'b0; busA.dm_we = 1'b0; busA.dm_addr = '0; busA.dm_wdata = 32'h0;
    busB.halted = 1'b0; busB.if_req = 1'b0; busB.if_addr = '0;
    busB.dm_req = 1'b0; busB.dm_we = 1'b0; busB.dm_addr = '0; busB.dm_wdata = 32'h0;

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    checkOutput("rstA_if_gnt",    busA.if_gnt,    32'h0);
    checkOutput("rstA_dm_gnt",    busA.dm_gnt,    32'h0);
    checkOutput("rstA_if_rvalid", busA.if_rvalid, 32'h0);
    checkOutput("rstA_dm_rvalid", busA.dm_rvalid, 32'h0);
    checkOutput("rstA_mem_en",    busA.mem_en,    32'h0);
    checkOutput("rstA_if_rdata",  busA.if_rdata,  32'h0);
    checkOutput("rstB_mem_en",    busB.mem_en,    32'h0);
    rst_n = 1'b1;

    // A: IF read of addr 5, MEM_LAT=1
    busA.if_req  = 1'b1;
    busA.if_addr = 10'd5;
    checkOutput("t1_c0_if_gnt", busA.if_gnt, 32'h0);
    tick();
    checkOutput("t1_c1_if_gnt",   busA.if_gnt,   32'h1);
    checkOutput("t1_c1_dm_gnt",   busA.dm_gnt,   32'h0);
    checkOutput("t1_c1_mem_en",   busA.mem_en,   32'h1);
    checkOutput("t1_c1_mem_we",   busA.mem_we,   32'h0);
    checkOutput("t1_c1_mem_addr", busA.mem_addr, 32'd5);
    tick();
    busA.if_req = 1'b0;
    checkOutput("t1_c2_if_rvalid", busA.if_rvalid, 32'h0);
    checkOutput("t1_c2_mem_en",    busA.mem_en,    32'h0);
    tick();
    checkOutput("t1_c3_if_rvalid", busA.if_rvalid, 32'h1);
    checkOutput("t1_c3_if_rdata",  busA.if_rdata,  32'h2842_000A);
    tick();
    checkOutput("t1_c4_if_rvalid", busA.if_rvalid, 32'h0);

    // A: DM store to 20 then load back
    busA.dm_req   = 1'b1;
    busA.dm_we    = 1'b1;
    busA.dm_addr  = 10'd20;
    busA.dm_wdata = 32'hDEAD_BEEF;
    tick();
    checkOutput("t2_st_dm_gnt",    busA.dm_gnt,    32'h1);
    checkOutput("t2_st_if_gnt",    busA.if_gnt,    32'h0);
    checkOutput("t2_st_mem_we",    busA.mem_we,    32'h1);
    checkOutput("t2_st_mem_addr",  busA.mem_addr,  32'd20);
    checkOutput("t2_st_mem_wdata", busA.mem_wdata, 32'hDEAD_BEEF);
    tick();
    busA.dm_req = 1'b0;
    busA.dm_we  = 1'b0;
    tick();
    checkOutput("t2_st_dm_rvalid", busA.dm_rvalid, 32'h1);
    checkOutput("t2_st_dm_rdata",  busA.dm_rdata,  32'h0);
    checkOutput("t2_st_if_rvalid", busA.if_rvalid, 32'h0);
    busA.dm_req  = 1'b1;
    busA.dm_we   = 1'b0;
    busA.dm_addr = 10'd20;
    tick();
    checkOutput("t2_ld_dm_gnt", busA.dm_gnt, 32'h1);
    checkOutput("t2_ld_mem_we", busA.mem_we, 32'h0);
    tick();
    busA.dm_req = 1'b0;
    tick();
    checkOutput("t2_ld_dm_rvalid", busA.dm_rvalid, 32'h1);
    checkOutput("t2_ld_dm_rdata",  busA.dm_rdata,  32'hDEAD_BEEF);
    checkOutput("t2_if_rdata_hold", busA.if_rdata, 32'h2842_000A);

    // A: both requesters held; expect DM x4 then IF, twice
    expDm = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
    busA.if_req  = 1'b1;
    busA.if_addr = 10'd5;
    busA.dm_req  = 1'b1;
    cyc     = 0;
    lastCyc = 0;
    for (int g = 0; g < 10; g++) begin
      waited = 0;
      while (!(busA.if_gnt || busA.dm_gnt) && (waited < 12)) begin
        tick();
        cyc++;
        waited++;
      end
      checkOutput($sformatf("t3_order%0d_dm_gnt", g), busA.dm_gnt, 32'(expDm[g]));
      checkOutput($sformatf("t3_order%0d_if_gnt", g), busA.if_gnt, 32'(!expDm[g]));
      if (g == 0) begin
        checkOutput("t3_first_latency", waited, 32'd1);
      end else begin
        checkOutput($sformatf("t3_spacing%0d", g), cyc - lastCyc, 32'd3);
      end
      lastCyc = cyc;
      tick();
      cyc++;
    end
    busA.if_req = 1'b0;
    busA.dm_req = 1'b0;
    tick();
    checkOutput("t3_last_if_rvalid", busA.if_rvalid, 32'h1);
    checkOutput("t3_last_if_rdata",  busA.if_rdata,  32'h2842_000A);
    tick();

    // B: single IF read, MEM_LAT=3
    busB.if_req  = 1'b1;
    busB.if_addr = 10'd5;
    memEnCnt = 0; memEnCyc = -1; gntCnt = 0; gntCyc = -1; rvCnt = 0; rvCyc = -1; rvData = 32'h0;
    for (int c = 0; c < 8; c++) begin
      if (busB.mem_en) begin memEnCnt++; memEnCyc = c; end
      if (busB.if_gnt || busB.dm_gnt) begin gntCnt++; gntCyc = c; end
      if (busB.if_rvalid) begin rvCnt++; rvCyc = c; rvData = busB.if_rdata; end
      if (c == 1) busB.if_req = 1'b0;
      tick();
    end
    checkOutput("t4_mem_en_count", memEnCnt, 32'd1);
    checkOutput("t4_mem_en_cycle", memEnCyc, 32'd1);
    checkOutput("t4_gnt_count",    gntCnt,   32'd1);
    checkOutput("t4_gnt_cycle",    gntCyc,   32'd1);
    checkOutput("t4_rvalid_count", rvCnt,    32'd1);
    checkOutput("t4_rvalid_cycle", rvCyc,    32'd5);
    checkOutput("t4_rdata",        rvData,   32'h2842_000A);

    // B: halted raised during WAIT of a DM load, IF waiting behind it
    busB.dm_req  = 1'b1;
    busB.dm_we   = 1'b0;
    busB.dm_addr = 10'd7;
    dmGntCyc = -1; dmRvCyc = -1; dmRvData = 32'h0; ifGntCnt = 0; ifGntCyc = -1; ifRvCyc = -1;
    for (int c = 0; c < 15; c++) begin
      if (busB.dm_gnt) dmGntCyc = c;
      if (busB.dm_rvalid) begin dmRvCyc = c; dmRvData = busB.dm_rdata; end
      if (busB.if_gnt) begin ifGntCnt++; ifGntCyc = c; end
      if (busB.if_rvalid) ifRvCyc = c;
      if (c == 1) busB.dm_req = 1'b0;
      if (c == 2) begin
        busB.halted  = 1'b1;
        busB.if_req  = 1'b1;
        busB.if_addr = 10'd5;
      end
      if (c == 8) busB.halted = 1'b0;
      if (c == 9) busB.if_req = 1'b0;
      tick();
    end
    checkOutput("t5_dm_gnt_cycle",    dmGntCyc, 32'd1);
    checkOutput("t5_dm_rvalid_cycle", dmRvCyc,  32'd5);
    checkOutput("t5_dm_rdata",        dmRvData, 32'h1234_5678);
    checkOutput("t5_if_gnt_count",    ifGntCnt, 32'd1);
    checkOutput("t5_if_gnt_cycle",    ifGntCyc, 32'd9);
    checkOutput("t5_if_rvalid_cycle", ifRvCyc,  32'd13);

    // B: reset pulled during WAIT
    busB.if_req  = 1'b1;
    busB.if_addr = 10'd9;
    tick();
    checkOutput("t6_if_gnt", busB.if_gnt, 32'h1);
    busB.if_req = 1'b0;
    tick();
    #2;
    rst_n = 1'b0;
    #1;
    checkOutput("t6_rst_if_gnt",    busB.if_gnt,    32'h0);
    checkOutput("t6_rst_dm_gnt",    busB.dm_gnt,    32'h0);
    checkOutput("t6_rst_if_rvalid", busB.if_rvalid, 32'h0);
    checkOutput("t6_rst_dm_rvalid", busB.dm_rvalid, 32'h0);
    checkOutput("t6_rst_if_rdata",  busB.if_rdata,  32'h0);
    checkOutput("t6_rst_dm_rdata",  busB.dm_rdata,  32'h0);
    checkOutput("t6_rst_mem_en",    busB.mem_en,    32'h0);
    checkOutput("t6_rst_mem_we",    busB.mem_we,    32'h0);
    checkOutput("t6_rst_mem_addr",  busB.mem_addr,  32'h0);
    checkOutput("t6_rst_mem_wdata", busB.mem_wdata, 32'h0);
    tick();
    rst_n = 1'b1;
    rvCnt = 0;
    for (int c = 0; c < 8; c++) begin
      if (busB.if_rvalid || busB.dm_rvalid) rvCnt++;
      tick();
    end
    checkOutput("t6_no_stale_rvalid", rvCnt, 32'd0);

    busB.if_req  = 1'b1;
    busB.if_addr = 10'd9;
    gntCnt = 0; gntCyc = -1; rvCnt = 0; rvCyc = -1; rvData = 32'h0;
    for (int c = 0; c < 8; c++) begin
      if (busB.if_gnt) begin gntCnt++; gntCyc = c; end
      if (busB.if_rvalid) begin rvCnt++; rvCyc = c; rvData = busB.if_rdata; end
      if (c == 1) busB.if_req = 1'b0;
      tick();
    end
    checkOutput("t6_new_gnt_count",    gntCnt, 32'd1);
    checkOutput("t6_new_gnt_cycle",    gntCyc, 32'd1);
    checkOutput("t6_new_rvalid_count", rvCnt,  32'd1);
    checkOutput("t6_new_rvalid_cycle", rvCyc,  32'd5);
    checkOutput("t6_new_rdata",        rvData, 32'hAAAA_5555);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
